// File: rtl/reg_file_sb_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
// Imported by the top and the busy-bit scoreboard.
package rf_pkg;

    localparam int RF_W     = 8;
    localparam int RF_A     = 2;
    localparam int RF_DEPTH = 2 ** RF_A;

    typedef logic [RF_A-1:0] rf_addr_t;
    typedef logic [RF_W-1:0] rf_data_t;

    // True when the address names the hardwired-zero register.
    function automatic logic isZeroReg(input int zeroRegEn, input int unsigned addr);
        return (zeroRegEn != 0) && (addr == 0);
    endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: one bit per register that marks an outstanding load.
// Decides reservation acceptance and serves two busy lookups.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int A        = RF_A,
    parameter int ZERO_REG = 0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ClearEn,
    input  logic [A-1:0] ClearAddr,
    input  logic         ReserveEn,
    input  logic [A-1:0] ReserveAddr,
    output logic         ReserveOk,
    input  logic [A-1:0] LookupAddrA,
    input  logic         BypassClrA,
    output logic         BusyA,
    input  logic [A-1:0] LookupAddrB,
    input  logic         BypassClrB,
    output logic         BusyB
);

    localparam int DEPTH = 2 ** A;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Acceptance looks only at the registered bit, so a load returning this
    // cycle cannot enable a reservation of the same register in the same cycle.
    always_comb begin
        ReserveOk = ReserveEn & ~busy_q[ReserveAddr];
        if (isZeroReg(ZERO_REG, 32'(ReserveAddr))) begin
            ReserveOk = 1'b0;
        end
    end

    // Clear first, then set, so a same-cycle return and reissue leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (ClearEn) begin
            busy_d[ClearAddr] = 1'b0;
        end
        if (ReserveOk) begin
            busy_d[ReserveAddr] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        BusyA = busy_q[LookupAddrA] & ~BypassClrA;
        BusyB = busy_q[LookupAddrB] & ~BypassClrB;
        if (isZeroReg(ZERO_REG, 32'(LookupAddrA))) begin
            BusyA = 1'b0;
        end
        if (isZeroReg(ZERO_REG, 32'(LookupAddrB))) begin
            BusyB = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Two-write, two-read register file with load scoreboard and optional
// write-to-read forwarding; the load-return port wins write conflicts.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int W        = RF_W,
    parameter int A        = RF_A,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [A-1:0] RaddrA,
    input  logic [A-1:0] RaddrB,
    output logic [W-1:0] DataOutA,
    output logic [W-1:0] DataOutB,
    output logic         BusyA,
    output logic         BusyB,
    input  logic         WenAlu,
    input  logic [A-1:0] WaddrAlu,
    input  logic [W-1:0] DataAlu,
    input  logic         WenLd,
    input  logic [A-1:0] WaddrLd,
    input  logic [W-1:0] DataLd,
    input  logic         ReserveEn,
    input  logic [A-1:0] ReserveAddr,
    output logic         ReserveOk,
    output logic         ConflictErr
);

    localparam int DEPTH = 2 ** A;

    logic [W-1:0] regs_q [DEPTH];
    logic [W-1:0] regs_d [DEPTH];
    logic         conflict_q;
    logic         conflict_d;
    logic         ldHitA;
    logic         ldHitB;
    logic         bypassClrA;
    logic         bypassClrB;

    // Forwarding mux: a returning load outranks the ALU, which outranks storage.
    function automatic logic [W-1:0] readPort(
        input logic [A-1:0] addr,
        input logic [W-1:0] stored,
        input logic         wenAlu,
        input logic [A-1:0] waddrAlu,
        input logic [W-1:0] dataAlu,
        input logic         wenLd,
        input logic [A-1:0] waddrLd,
        input logic [W-1:0] dataLd
    );
        logic [W-1:0] result;
        result = stored;
        if (BYPASS != 0) begin
            if (wenLd && (waddrLd == addr)) begin
                result = dataLd;
            end else if (wenAlu && (waddrAlu == addr)) begin
                result = dataAlu;
            end
        end
        if (isZeroReg(ZERO_REG, 32'(addr))) begin
            result = '0;
        end
        return result;
    endfunction

    // Load data is applied after ALU data so it overwrites on a shared address.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (WenAlu) begin
            regs_d[WaddrAlu] = DataAlu;
        end
        if (WenLd) begin
            regs_d[WaddrLd] = DataLd;
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
        end
    end

    assign conflict_d = WenAlu & WenLd & (WaddrAlu == WaddrLd);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            conflict_q <= conflict_d;
        end
    end

    assign ConflictErr = conflict_q;

    assign ldHitA     = WenLd & (WaddrLd == RaddrA);
    assign ldHitB     = WenLd & (WaddrLd == RaddrB);
    assign bypassClrA = (BYPASS != 0) ? ldHitA : 1'b0;
    assign bypassClrB = (BYPASS != 0) ? ldHitB : 1'b0;

    always_comb begin
        DataOutA = readPort(RaddrA, regs_q[RaddrA], WenAlu, WaddrAlu, DataAlu,
                            WenLd, WaddrLd, DataLd);
        DataOutB = readPort(RaddrB, regs_q[RaddrB], WenAlu, WaddrAlu, DataAlu,
                            WenLd, WaddrLd, DataLd);
    end

    rf_scoreboard #(
        .A        (A),
        .ZERO_REG (ZERO_REG)
    ) uScoreboard (
        .Clk         (Clk),
        .Reset       (Reset),
        .ClearEn     (WenLd),
        .ClearAddr   (WaddrLd),
        .ReserveEn   (ReserveEn),
        .ReserveAddr (ReserveAddr),
        .ReserveOk   (ReserveOk),
        .LookupAddrA (RaddrA),
        .BypassClrA  (bypassClrA),
        .BusyA       (BusyA),
        .LookupAddrB (RaddrB),
        .BypassClrB  (bypassClrB),
        .BusyB       (BusyB)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: three instances share stimulus to cover
// BYPASS=1, BYPASS=0 and ZERO_REG=1 configurations.
module tb_reg_file_sb;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] RaddrA, RaddrB, WaddrAlu, WaddrLd, ReserveAddr;
    logic [7:0] DataAlu, DataLd;
    logic       WenAlu, WenLd, ReserveEn;

    logic [7:0] bDataA, bDataB, nDataA, nDataB, zDataA, zDataB;
    logic       bBusyA, bBusyB, bOk, bConf;
    logic       nBusyA, nBusyB, nOk, nConf;
    logic       zBusyA, zBusyB, zOk, zConf;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    reg_file_sb #(.W(8), .A(2), .ZERO_REG(0), .BYPASS(1)) dutB (
        .Clk(Clk), .Reset(Reset), .RaddrA(RaddrA), .RaddrB(RaddrB),
        .DataOutA(bDataA), .DataOutB(bDataB), .BusyA(bBusyA), .BusyB(bBusyB),
        .WenAlu(WenAlu), .WaddrAlu(WaddrAlu), .DataAlu(DataAlu),
        .WenLd(WenLd), .WaddrLd(WaddrLd), .DataLd(DataLd),
        .ReserveEn(ReserveEn), .ReserveAddr(ReserveAddr),
        .ReserveOk(bOk), .ConflictErr(bConf));

    reg_file_sb #(.W(8), .A(2), .ZERO_REG(0), .BYPASS(0)) dutN (
        .Clk(Clk), .Reset(Reset), .RaddrA(RaddrA), .RaddrB(RaddrB),
        .DataOutA(nDataA), .DataOutB(nDataB), .BusyA(nBusyA), .BusyB(nBusyB),
        .WenAlu(WenAlu), .WaddrAlu(WaddrAlu), .DataAlu(DataAlu),
        .WenLd(WenLd), .WaddrLd(WaddrLd), .DataLd(DataLd),
        .ReserveEn(ReserveEn), .ReserveAddr(ReserveAddr),
        .ReserveOk(nOk), .ConflictErr(nConf));

    reg_file_sb #(.W(8), .A(2), .ZERO_REG(1), .BYPASS(1)) dutZ (
        .Clk(Clk), .Reset(Reset), .RaddrA(RaddrA), .RaddrB(RaddrB),
        .DataOutA(zDataA), .DataOutB(zDataB), .BusyA(zBusyA), .BusyB(zBusyB),
        .WenAlu(WenAlu), .WaddrAlu(WaddrAlu), .DataAlu(DataAlu),
        .WenLd(WenLd), .WaddrLd(WaddrLd), .DataLd(DataLd),
        .ReserveEn(ReserveEn), .ReserveAddr(ReserveAddr),
        .ReserveOk(zOk), .ConflictErr(zConf));

    // Columns: wenAlu waddrAlu dataAlu wenLd waddrLd dataLd resEn resAddr rA rB
    //          expA expB expBusyA expBusyB expOk expConf (pre-edge, BYPASS=1 instance)
    typedef struct {
        logic       wenAlu;
        logic [1:0] waddrAlu;
        logic [7:0] dataAlu;
        logic       wenLd;
        logic [1:0] waddrLd;
        logic [7:0] dataLd;
        logic       resEn;
        logic [1:0] resAddr;
        logic [1:0] rA;
        logic [1:0] rB;
        logic [7:0] expA;
        logic [7:0] expB;
        logic       expBusyA;
        logic       expBusyB;
        logic       expOk;
        logic       expConf;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic applyStimulus(input vec_t v);
        WenAlu      = v.wenAlu;
        WaddrAlu    = v.waddrAlu;
        DataAlu     = v.dataAlu;
        WenLd       = v.wenLd;
        WaddrLd     = v.waddrLd;
        DataLd      = v.dataLd;
        ReserveEn   = v.resEn;
        ReserveAddr = v.resAddr;
        RaddrA      = v.rA;
        RaddrB      = v.rB;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle(input logic [1:0] ra, input logic [1:0] rb);
        applyStimulus('{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, ra, rb,
                        8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic stepEdge();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1,2'd1,8'h11, 1,2'd2,8'h22, 0,2'd0, 2'd1,2'd2, 8'h11,8'h22, 0,0,0,0};
        vecs[1]  = '{0,2'd0,8'h00, 0,2'd0,8'h00, 0,2'd0, 2'd1,2'd2, 8'h11,8'h22, 0,0,0,0};
        vecs[2]  = '{1,2'd3,8'hAA, 1,2'd3,8'hBB, 0,2'd0, 2'd3,2'd3, 8'hBB,8'hBB, 0,0,0,0};
        vecs[3]  = '{0,2'd0,8'h00, 0,2'd0,8'h00, 0,2'd0, 2'd3,2'd1, 8'hBB,8'h11, 0,0,0,1};
        vecs[4]  = '{0,2'd0,8'h00, 0,2'd0,8'h00, 0,2'd0, 2'd3,2'd0, 8'hBB,8'h00, 0,0,0,0};
        vecs[5]  = '{0,2'd0,8'h00, 0,2'd0,8'h00, 1,2'd2, 2'd2,2'd1, 8'h22,8'h11, 0,0,1,0};
        vecs[6]  = '{0,2'd0,8'h00, 0,2'd0,8'h00, 1,2'd2, 2'd2,2'd1, 8'h22,8'h11, 1,0,0,0};
        vecs[7]  = '{0,2'd0,8'h00, 1,2'd2,8'h7E, 0,2'd0, 2'd2,2'd2, 8'h7E,8'h7E, 0,0,0,0};
        vecs[8]  = '{0,2'd0,8'h00, 0,2'd0,8'h00, 1,2'd1, 2'd1,2'd2, 8'h11,8'h7E, 0,0,1,0};
        vecs[9]  = '{0,2'd0,8'h00, 1,2'd1,8'h33, 1,2'd1, 2'd1,2'd1, 8'h33,8'h33, 0,0,0,0};
        vecs[10] = '{0,2'd0,8'h00, 0,2'd0,8'h00, 1,2'd1, 2'd1,2'd3, 8'h33,8'hBB, 0,0,1,0};
        vecs[11] = '{0,2'd0,8'h00, 0,2'd0,8'h00, 0,2'd0, 2'd1,2'd2, 8'h33,8'h7E, 1,0,0,0};
        vecs[12] = '{1,2'd0,8'h44, 1,2'd0,8'h66, 0,2'd0, 2'd0,2'd1, 8'h66,8'h33, 0,1,0,0};
        vecs[13] = '{0,2'd0,8'h00, 0,2'd0,8'h00, 0,2'd0, 2'd0,2'd0, 8'h66,8'h66, 0,0,0,1};
        vecs[14] = '{1,2'd1,8'h55, 0,2'd0,8'h00, 0,2'd0, 2'd1,2'd1, 8'h55,8'h55, 1,1,0,0};
        vecs[15] = '{0,2'd0,8'h00, 0,2'd0,8'h00, 0,2'd0, 2'd1,2'd0, 8'h55,8'h66, 1,0,0,0};
        vecs[16] = '{0,2'd0,8'h00, 1,2'd2,8'h9C, 1,2'd2, 2'd2,2'd3, 8'h9C,8'hBB, 0,0,1,0};
        vecs[17] = '{0,2'd0,8'h00, 0,2'd0,8'h00, 0,2'd0, 2'd2,2'd1, 8'h9C,8'h55, 1,1,0,0};

        // Reset wins over a concurrent ALU write to r2.
        idle(2'd2, 2'd2);
        Reset    = 1'b1;
        WenAlu   = 1'b1;
        WaddrAlu = 2'd2;
        DataAlu  = 8'h55;
        stepEdge();
        Reset = 1'b0;
        for (int r = 0; r < 4; r++) begin
            idle(2'(r), 2'(r));
            #1;
            checkOutput($sformatf("rst_dataA_r%0d", r), bDataA, 8'h00);
            checkOutput($sformatf("rst_dataB_r%0d", r), bDataB, 8'h00);
            checkOutput($sformatf("rst_busyA_r%0d", r), {7'd0, bBusyA}, 8'h00);
            checkOutput($sformatf("rst_busyB_r%0d", r), {7'd0, bBusyB}, 8'h00);
        end
        checkOutput("rst_conf", {7'd0, bConf}, 8'h00);
        checkOutput("rst_nodata", nDataA, 8'h00);
        stepEdge();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #3;
            checkOutput($sformatf("v%0d_dataA", i), bDataA, vecs[i].expA);
            checkOutput($sformatf("v%0d_dataB", i), bDataB, vecs[i].expB);
            checkOutput($sformatf("v%0d_busyA", i), {7'd0, bBusyA}, {7'd0, vecs[i].expBusyA});
            checkOutput($sformatf("v%0d_busyB", i), {7'd0, bBusyB}, {7'd0, vecs[i].expBusyB});
            checkOutput($sformatf("v%0d_resOk", i), {7'd0, bOk}, {7'd0, vecs[i].expOk});
            checkOutput($sformatf("v%0d_conf", i), {7'd0, bConf}, {7'd0, vecs[i].expConf});
            stepEdge();
        end

        // Fresh state for the cross-configuration sequences.
        idle(2'd0, 2'd0);
        Reset = 1'b1;
        stepEdge();
        Reset = 1'b0;

        // Same-address dual write to r0: forwarding vs. storage vs. hardwired zero.
        WenAlu = 1'b1; WaddrAlu = 2'd0; DataAlu = 8'h44;
        WenLd  = 1'b1; WaddrLd  = 2'd0; DataLd  = 8'h66;
        #3;
        checkOutput("byp_B_pre", bDataA, 8'h66);
        checkOutput("byp_N_pre", nDataA, 8'h00);
        checkOutput("byp_Z_pre", zDataA, 8'h00);
        stepEdge();
        idle(2'd0, 2'd0);
        #1;
        checkOutput("byp_B_post", bDataA, 8'h66);
        checkOutput("byp_N_post", nDataA, 8'h66);
        checkOutput("byp_Z_post", zDataA, 8'h00);
        checkOutput("conf_N_r0", {7'd0, nConf}, 8'h01);
        checkOutput("conf_Z_r0", {7'd0, zConf}, 8'h01);
        stepEdge();
        checkOutput("conf_N_clear", {7'd0, nConf}, 8'h00);

        // Without bypass a returning load does not hide busy or forward data.
        idle(2'd3, 2'd3);
        ReserveEn = 1'b1; ReserveAddr = 2'd3;
        #1;
        checkOutput("nb_resOk", {7'd0, nOk}, 8'h01);
        stepEdge();
        idle(2'd3, 2'd3);
        WenLd = 1'b1; WaddrLd = 2'd3; DataLd = 8'h12;
        #1;
        checkOutput("nb_busyA_pre", {7'd0, nBusyA}, 8'h01);
        checkOutput("nb_dataA_pre", nDataA, 8'h00);
        checkOutput("b_busyA_ld", {7'd0, bBusyA}, 8'h00);
        checkOutput("b_dataA_ld", bDataA, 8'h12);
        stepEdge();
        idle(2'd3, 2'd3);
        #1;
        checkOutput("nb_dataA_post", nDataA, 8'h12);
        checkOutput("nb_busyA_post", {7'd0, nBusyA}, 8'h00);

        // Hardwired zero ignores writes and reservations on r0.
        idle(2'd0, 2'd0);
        WenAlu = 1'b1; WaddrAlu = 2'd0; DataAlu = 8'hFF;
        ReserveEn = 1'b1; ReserveAddr = 2'd0;
        #1;
        checkOutput("z_resOk_pre", {7'd0, zOk}, 8'h00);
        checkOutput("z_dataA_pre", zDataA, 8'h00);
        checkOutput("b_resOk_r0", {7'd0, bOk}, 8'h01);
        checkOutput("b_dataA_r0", bDataA, 8'hFF);
        stepEdge();
        idle(2'd0, 2'd0);
        ReserveEn = 1'b1; ReserveAddr = 2'd0;
        #1;
        checkOutput("z_dataA_post", zDataA, 8'h00);
        checkOutput("z_busyA_post", {7'd0, zBusyA}, 8'h00);
        checkOutput("z_resOk_post", {7'd0, zOk}, 8'h00);
        checkOutput("b_busyA_r0", {7'd0, bBusyA}, 8'h01);
        checkOutput("b_resOk_deny", {7'd0, bOk}, 8'h00);
        stepEdge();

        // A load returning during reset is dropped and busy bits clear.
        idle(2'd0, 2'd1);
        Reset = 1'b1;
        WenLd = 1'b1; WaddrLd = 2'd1; DataLd = 8'h77;
        stepEdge();
        Reset = 1'b0;
        idle(2'd0, 2'd1);
        #1;
        checkOutput("rst2_busyA", {7'd0, bBusyA}, 8'h00);
        checkOutput("rst2_dataA", bDataA, 8'h00);
        checkOutput("rst2_dataB", bDataB, 8'h00);
        checkOutput("rst2_conf", {7'd0, bConf}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised two-write, two-read register file with a per-register busy scoreboard and optional write-to-read bypass.
- Successor to the basic 4-entry 8-bit register file. Adds a second write port for load returns, hazard tracking for outstanding loads, and an optional hardwired-zero register.
- Sits between decode (read and reserve) and execute/memory writeback.

Parameters:
- W, 8, data width in bits.
- A, 2, address width; depth = 2**A registers.
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes and reservations.
- BYPASS, 1, when 1 same-cycle write data is forwarded to the read ports.

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous active-high reset
- RaddrA  in  A  read address, port A
- RaddrB  in  A  read address, port B
- DataOutA  out  W  read data, port A (combinational)
- DataOutB  out  W  read data, port B (combinational)
- BusyA  out  1  register at RaddrA has a pending load
- BusyB  out  1  register at RaddrB has a pending load
- WenAlu  in  1  ALU writeback enable
- WaddrAlu  in  A  ALU writeback address
- DataAlu  in  W  ALU writeback data
- WenLd  in  1  load-return writeback enable; clears the busy bit
- WaddrLd  in  A  load-return address
- DataLd  in  W  load-return data
- ReserveEn  in  1  request to mark ReserveAddr busy (load issued)
- ReserveAddr  in  A  register to reserve
- ReserveOk  out  1  reservation accepted this cycle (combinational)
- ConflictErr  out  1  registered one-cycle pulse: both write ports targeted the same address

Behaviour:
- Reset (synchronous, active-high) overrides all other inputs. Next edge: all registers = 0, all busy bits = 0, ConflictErr = 0. A pending load returning during reset is dropped.
- Writes:
  - Registered on the rising edge.
  - WenAlu writes DataAlu to WaddrAlu; WenLd writes DataLd to WaddrLd.
  - Both enabled to different addresses: both are written.
  - Both enabled to the same address: DataLd wins, and ConflictErr = 1 on the following cycle only.
- Busy bits:
  - An edge with WenLd clears busy[WaddrLd].
  - An edge with ReserveOk sets busy[ReserveAddr].
  - Same address, same cycle: the clear is applied first, then the set, so the bit ends up 1 (a new load is outstanding).
  - WenAlu never changes busy bits.
- ReserveOk = ReserveEn & ~busy[ReserveAddr], using the registered busy bit, & ~(ZERO_REG && ReserveAddr==0).
  - A denied reservation changes no state.
  - Decode must stall and retry until ReserveOk is 1.
- Reads:
  - Latency 0 (combinational).
  - BYPASS=0: DataOutX = Registers[RaddrX]; BusyX = busy[RaddrX].
  - BYPASS=1, forwarding priority: if WenLd and WaddrLd==RaddrX, output DataLd; else if WenAlu and WaddrAlu==RaddrX, output DataAlu; else output the stored value.
  - BYPASS=1, busy: BusyX = busy[RaddrX] & ~(WenLd & WaddrLd==RaddrX).
- ZERO_REG=1:
  - Reads of address 0 return 0 and BusyX = 0, regardless of bypass.
  - Writes and reservations to address 0 are ignored.
  - A same-address write conflict on address 0 still pulses ConflictErr.
- Depth wrap: not applicable. Every A-bit address is valid.

Decomposition:
- Package rf_pkg:
  - Parameters RF_W=8, RF_A=2.
  - Typedefs rf_addr_t and rf_data_t.
  - Localparam RF_DEPTH = 2**RF_A.
- Sub-module rf_scoreboard (A as parameter).
  - Holds the busy vector.
  - Handles the set/clear ordering and the ReserveOk computation.
  - Provides two busy lookups, with bypass-clear inputs.
- The top module holds the data array, write arbitration, bypass muxes and the ConflictErr flop.

Test Plan (W=8, A=2):
- Reset then read: assert Reset for 1 edge with WenAlu=1 to r2=0x55 → all DataOut=0x00, BusyA/B=0, ConflictErr=0.
- Dual write: WenAlu r1=0x11 and WenLd r2=0x22 on the same edge → next cycle RaddrA=1 gives 0x11, RaddrB=2 gives 0x22. Then both ports to r3 with Alu=0xAA, Ld=0xBB → r3=0xBB, ConflictErr=1 for exactly one cycle.
- Scoreboard:
  - ReserveEn r2 → ReserveOk=1, then BusyA=1 with RaddrA=2.
  - Second ReserveEn r2 → ReserveOk=0.
  - WenLd r2=0x7E → BusyA=0 in the same cycle; DataOutA=0x7E combinationally.
- Clear+reserve same cycle: r1 busy, WenLd r1=0x33 with ReserveEn r1 → ReserveOk=0 (registered busy=1), so busy ends at 0. Retry the reserve next cycle → ReserveOk=1, busy=1.
- Bypass priority, BYPASS=1: r0 stored 0x00, same-cycle WenAlu r0=0x44 and WenLd r0=0x66 → DataOutA=0x66 before the edge. With BYPASS=0 → 0x00 before the edge, 0x66 after.
- ZERO_REG=1: WenAlu r0=0xFF and ReserveEn r0 → ReserveOk=0, DataOutA(r0)=0x00 before and after the edge, BusyA=0.
